mouse_cursor: RTL and testbench
===============================

MOUSE_CURSOR -- requirements
Module: mouse_cursor

Interface
REQ-001 SHALL provide parameter H_MAX, default 639, maximum cursor X; legal range 255..1023.
REQ-002 SHALL provide parameter V_MAX, default 479, maximum cursor Y; legal range 255..1023.
REQ-003 SHALL provide parameter X_INIT, default 320, X value after reset or recenter.
REQ-004 SHALL provide parameter Y_INIT, default 240, Y value after reset or recenter.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pkt_valid  input  1  one-cycle pulse from the mouse packet decoder: dx/dy/btn are valid.
REQ-008 SHALL have port dx  input  9  signed two's-complement X movement, positive = right.
REQ-009 SHALL have port dy  input  9  signed two's-complement Y movement, positive = up.
REQ-010 SHALL have port btn  input  3  button levels {middle, right, left}.
REQ-011 SHALL have port recenter  input  1  synchronous request to return the cursor to X_INIT/Y_INIT.
REQ-012 SHALL have port cursor_x  output  10  current X, 0..H_MAX.
REQ-013 SHALL have port cursor_y  output  10  current Y, 0..V_MAX, 0 = top.
REQ-014 SHALL have port btn_q  output  3  registered button levels.
REQ-015 SHALL have port btn_press  output  3  one-cycle rising-edge pulses per button.
REQ-016 SHALL have port btn_release  output  3  one-cycle falling-edge pulses per button.
REQ-017 SHALL have port update_tick  output  1  one-cycle pulse when new cursor/button values are committed.
REQ-018 SHALL have port busy  output  1  high while FSM not in IDLE.
REQ-019 SHALL have port drop_cnt  output  8  saturating count of packets lost while busy.

Function
REQ-020 SHALL implement FSM states IDLE, CALC, COMMIT; IDLE->CALC on pkt_valid, CALC->COMMIT, COMMIT->IDLE, unconditionally.
REQ-021 SHALL latch dx, dy, btn on the edge that samples pkt_valid high in IDLE.
REQ-022 SHALL in CALC register sum_x = cursor_x + sext(dx) and sum_y = cursor_y - sext(dy), both as 12-bit signed values.
REQ-023 SHALL in COMMIT clamp sums: below 0 -> 0, above H_MAX/V_MAX -> H_MAX/V_MAX, else unchanged.
REQ-024 SHALL update cursor_x, cursor_y, btn_q and assert update_tick for exactly one cycle on the edge leaving COMMIT (3 edges after the pkt_valid sampling edge).
REQ-025 SHALL assert btn_press[i]/btn_release[i] in the same cycle as update_tick when btn_q[i] changes 0->1 / 1->0; zero otherwise.
REQ-026 SHALL ignore pkt_valid in CALC or COMMIT and increment drop_cnt, holding at 255.
REQ-027 SHALL accept a pkt_valid arriving in the cycle update_tick is high (FSM in IDLE), with no drop.
REQ-028 SHALL on recenter (any state) set cursor to X_INIT/Y_INIT on the next edge, force IDLE, discard any in-flight packet without update_tick or drop count, and leave btn_q unchanged.
REQ-029 SHALL give recenter priority over a simultaneous pkt_valid; that packet is discarded and not counted.
REQ-030 SHALL keep busy = (state != IDLE).

Reset
REQ-031 SHALL on rst set cursor_x=X_INIT, cursor_y=Y_INIT, btn_q=0, btn_press=0, btn_release=0, update_tick=0, drop_cnt=0, state IDLE, busy=0.
REQ-032 SHALL on rst asserted mid-packet abandon the packet with no update_tick after rst release.

Configuration
REQ-033 SHALL with macro MOUSE_CURSOR_WRAP_EN defined replace clamping with wrap: sum<0 -> sum+(MAX+1), sum>MAX -> sum-(MAX+1); one correction suffices given MAX>=255.
REQ-034 SHALL without MOUSE_CURSOR_WRAP_EN use clamping per REQ-023; all other behaviour is identical in both builds.

Verification
REQ-035 SHALL cover: reset, then pkt dx=+10, dy=+5, btn=001 -> 3 edges later cursor=(330,235), btn_press=001, update_tick one cycle.
REQ-036 SHALL cover: cursor (5,470), pkt dx=-256 (0x100), dy=-255 (0x101) -> clamp build (0,479); wrap build (389,245).
REQ-037 SHALL cover: pkt_valid, then second pkt_valid 1 cycle later -> second dropped, drop_cnt=1, single update_tick; 300 such drops -> drop_cnt=255.
REQ-038 SHALL cover: btn 001 -> 000 across two packets -> btn_release=001 on second update_tick, btn_press=000.
REQ-039 SHALL cover: recenter asserted in CALC -> next edge cursor=(320,240), state IDLE, no update_tick, drop_cnt unchanged.
REQ-040 SHALL cover: rst pulsed during COMMIT -> all outputs at reset values, no update_tick for that packet.

Source files
------------

// File: rtl/mouse_cursor.sv
// Mouse cursor tracker: accumulates packet deltas into a bounded cursor position and tracks button edges.
// Optional build macro MOUSE_CURSOR_WRAP_EN makes the cursor wrap at the screen edges instead of clamping.
module mouse_cursor #(
    parameter int unsigned H_MAX  = 639,
    parameter int unsigned V_MAX  = 479,
    parameter int unsigned X_INIT = 320,
    parameter int unsigned Y_INIT = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [8:0] dx,
    input  logic [8:0] dy,
    input  logic [2:0] btn,
    input  logic       recenter,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic [2:0] btn_q,
    output logic [2:0] btn_press,
    output logic [2:0] btn_release,
    output logic       update_tick,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int unsigned SW = 12;
    localparam logic signed [SW-1:0] H_MAX_S = SW'(H_MAX);
    localparam logic signed [SW-1:0] V_MAX_S = SW'(V_MAX);
    localparam logic signed [SW-1:0] H_PER_S = SW'(H_MAX + 1);
    localparam logic signed [SW-1:0] V_PER_S = SW'(V_MAX + 1);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t               state_q, state_d;
    logic [8:0]           dx_q, dx_d, dy_q, dy_d;
    logic [2:0]           btn_lat_q, btn_lat_d;
    logic signed [SW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [9:0]           cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
    logic [2:0]           btn_lvl_q, btn_lvl_d;
    logic [2:0]           btn_press_q, btn_press_d, btn_release_q, btn_release_d;
    logic                 update_tick_q, update_tick_d;
    logic                 busy_q, busy_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    // Bring a 12-bit signed sum back into 0..mx; sums never exceed one period outside the range.
    function automatic logic [9:0] fit(input logic signed [SW-1:0] s,
                                       input logic signed [SW-1:0] mx,
                                       input logic signed [SW-1:0] per);
        logic signed [SW-1:0] r;
`ifdef MOUSE_CURSOR_WRAP_EN
        if (s[SW-1])     r = s + per;
        else if (s > mx) r = s - per;
        else             r = s;
`else
        if (s[SW-1])     r = '0;
        else if (s > mx) r = mx;
        else             r = s;
        if (per == '0)   r = '0;
`endif
        return r[9:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        btn_lat_d     = btn_lat_q;
        sum_x_d       = sum_x_q;
        sum_y_d       = sum_y_q;
        cursor_x_d    = cursor_x_q;
        cursor_y_d    = cursor_y_q;
        btn_lvl_d     = btn_lvl_q;
        btn_press_d   = '0;
        btn_release_d = '0;
        update_tick_d = 1'b0;
        drop_cnt_d    = drop_cnt_q;

        if (recenter) begin
            // Abort any in-flight packet; a concurrent pkt_valid is discarded uncounted.
            state_d    = IDLE;
            cursor_x_d = 10'(X_INIT);
            cursor_y_d = 10'(Y_INIT);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pkt_valid) begin
                        dx_d      = dx;
                        dy_d      = dy;
                        btn_lat_d = btn;
                        state_d   = CALC;
                    end
                end
                CALC: begin
                    sum_x_d = $signed({2'b00, cursor_x_q}) + $signed({{3{dx_q[8]}}, dx_q});
                    sum_y_d = $signed({2'b00, cursor_y_q}) - $signed({{3{dy_q[8]}}, dy_q});
                    state_d = COMMIT;
                end
                COMMIT: begin
                    cursor_x_d    = fit(sum_x_q, H_MAX_S, H_PER_S);
                    cursor_y_d    = fit(sum_y_q, V_MAX_S, V_PER_S);
                    btn_lvl_d     = btn_lat_q;
                    btn_press_d   = btn_lat_q & ~btn_lvl_q;
                    btn_release_d = ~btn_lat_q & btn_lvl_q;
                    update_tick_d = 1'b1;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (pkt_valid && state_q != IDLE && drop_cnt_q != 8'hFF)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            dx_q          <= '0;
            dy_q          <= '0;
            btn_lat_q     <= '0;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            cursor_x_q    <= 10'(X_INIT);
            cursor_y_q    <= 10'(Y_INIT);
            btn_lvl_q     <= '0;
            btn_press_q   <= '0;
            btn_release_q <= '0;
            update_tick_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            btn_lat_q     <= btn_lat_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
            btn_lvl_q     <= btn_lvl_d;
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
            update_tick_q <= update_tick_d;
            busy_q        <= busy_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign cursor_x    = cursor_x_q;
    assign cursor_y    = cursor_y_q;
    assign btn_q       = btn_lvl_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;
    assign update_tick = update_tick_q;
    assign busy        = busy_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mouse_cursor.sv
// Testbench for mouse_cursor: directed scenarios plus random traffic against a packet-level model.
// Honours MOUSE_CURSOR_WRAP_EN so the model matches whichever build is compiled.
module tb_mouse_cursor;

    localparam int H_MAX  = 639;
    localparam int V_MAX  = 479;
    localparam int X_INIT = 320;
    localparam int Y_INIT = 240;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [8:0] dx, dy;
    logic [2:0] btn;
    logic       recenter;
    logic [9:0] cursor_x, cursor_y;
    logic [2:0] btn_q, btn_press, btn_release;
    logic       update_tick, busy;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: cursor/buttons, plus the packet still in flight and how many edges until it lands.
    int m_cx, m_cy, m_bq, m_press, m_rel, m_tick, m_drop, m_left;
    int p_dx, p_dy, p_btn;

    mouse_cursor #(.H_MAX(H_MAX), .V_MAX(V_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .dx(dx), .dy(dy), .btn(btn),
        .recenter(recenter), .cursor_x(cursor_x), .cursor_y(cursor_y), .btn_q(btn_q),
        .btn_press(btn_press), .btn_release(btn_release), .update_tick(update_tick),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fit(input int v, input int mx);
`ifdef MOUSE_CURSOR_WRAP_EN
        return ((v % (mx + 1)) + (mx + 1)) % (mx + 1);
`else
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
`endif
    endfunction

    task automatic model_reset();
        m_cx = X_INIT; m_cy = Y_INIT; m_bq = 0; m_press = 0; m_rel = 0;
        m_tick = 0; m_drop = 0; m_left = 0;
    endtask

    task automatic model_step(input bit pv, input logic [8:0] ddx, input logic [8:0] ddy,
                              input logic [2:0] b, input bit rc);
        m_tick = 0; m_press = 0; m_rel = 0;
        if (rc) begin
            m_cx = X_INIT; m_cy = Y_INIT; m_left = 0;
        end else if (m_left == 0) begin
            if (pv) begin
                m_left = 2;
                p_dx = $signed(ddx); p_dy = $signed(ddy); p_btn = int'(b);
            end
        end else begin
            if (pv && m_drop < 255) m_drop++;
            m_left--;
            if (m_left == 0) begin
                m_cx    = fit(m_cx + p_dx, H_MAX);
                m_cy    = fit(m_cy - p_dy, V_MAX);
                m_press = p_btn & ~m_bq & 7;
                m_rel   = ~p_btn & m_bq & 7;
                m_bq    = p_btn;
                m_tick  = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("cursor_x", int'(cursor_x), m_cx);
        check("cursor_y", int'(cursor_y), m_cy);
        check("btn_q", int'(btn_q), m_bq);
        check("btn_press", int'(btn_press), m_press);
        check("btn_release", int'(btn_release), m_rel);
        check("update_tick", int'(update_tick), m_tick);
        check("busy", int'(busy), (m_left != 0) ? 1 : 0);
        check("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    task automatic cycle(input bit pv, input logic [8:0] ddx, input logic [8:0] ddy,
                         input logic [2:0] b, input bit rc);
        @(negedge clk);
        pkt_valid = pv; dx = ddx; dy = ddy; btn = b; recenter = rc;
        @(posedge clk);
        model_step(pv, ddx, ddy, b, rc);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 9'd0, 9'd0, 3'd0, 1'b0);
    endtask

    // One packet followed by the two idle edges that carry it to commit.
    task automatic pkt(input logic [8:0] ddx, input logic [8:0] ddy, input logic [2:0] b);
        cycle(1'b1, ddx, ddy, b, 1'b0);
        idle();
        idle();
    endtask

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; dx = '0; dy = '0; btn = '0; recenter = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_cursor_x", int'(cursor_x), 320);
        check("rst_cursor_y", int'(cursor_y), 240);
        @(negedge clk);
        rst = 1'b0;

        // Basic move right/up with left button press.
        pkt(9'd10, 9'd5, 3'b001);
        check("basic_x", int'(cursor_x), 330);
        check("basic_y", int'(cursor_y), 235);
        check("basic_press", int'(btn_press), 1);
        check("basic_tick", int'(update_tick), 1);
        idle();
        check("basic_tick_gone", int'(update_tick), 0);

        // Walk to (5,470), then push past both edges.
        pkt(9'h100, 9'h115, 3'b001);
        pkt(9'h1BB, 9'd0, 3'b001);
        check("pre_edge_x", int'(cursor_x), 5);
        check("pre_edge_y", int'(cursor_y), 470);
        pkt(9'h100, 9'h101, 3'b001);
`ifdef MOUSE_CURSOR_WRAP_EN
        check("edge_x", int'(cursor_x), 389);
        check("edge_y", int'(cursor_y), 245);
`else
        check("edge_x", int'(cursor_x), 0);
        check("edge_y", int'(cursor_y), 479);
`endif

        // Left button release.
        pkt(9'd0, 9'd0, 3'b000);
        check("release", int'(btn_release), 1);
        check("release_press", int'(btn_press), 0);

        // Back-to-back packet gets dropped; only one commit.
        cycle(1'b1, 9'd3, 9'd0, 3'b010, 1'b0);
        cycle(1'b1, 9'd7, 9'd0, 3'b100, 1'b0);
        check("drop_one", int'(drop_cnt), 1);
        idle();
        check("drop_tick", int'(update_tick), 1);
        check("drop_btn", int'(btn_q), 2);
        idle();
        check("drop_single_tick", int'(update_tick), 0);

        // Saturate the drop counter, with a continuous stream accepted right on tick cycles.
        for (int i = 0; i < 150; i++) begin
            cycle(1'b1, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 3'($urandom), 1'b0);
            cycle(1'b1, 9'd1, 9'd1, 3'd0, 1'b0);
            cycle(1'b1, 9'd1, 9'd1, 3'd0, 1'b0);
        end
        idle(); idle(); idle();
        check("drop_sat", int'(drop_cnt), 255);

        // Recenter while in CALC aborts the packet.
        cycle(1'b1, 9'd20, 9'd20, 3'b111, 1'b0);
        cycle(1'b0, 9'd0, 9'd0, 3'd0, 1'b1);
        check("rc_x", int'(cursor_x), 320);
        check("rc_y", int'(cursor_y), 240);
        check("rc_busy", int'(busy), 0);
        check("rc_drop", int'(drop_cnt), 255);
        idle();
        check("rc_no_tick", int'(update_tick), 0);

        // Recenter beats a simultaneous packet.
        cycle(1'b1, 9'd50, 9'd50, 3'b111, 1'b1);
        check("rc_pv_busy", int'(busy), 0);
        idle(); idle();

        // Reset pulsed during COMMIT.
        cycle(1'b1, 9'd9, 9'd9, 3'b101, 1'b0);
        idle();
        check("pre_rst_busy", int'(busy), 1);
        @(negedge clk);
        pkt_valid = 1'b0; rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("rst_mid_drop", int'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("rst_no_tick", int'(update_tick), 0);
        end

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 99) < 40), 9'($urandom_range(0, 511)),
                  9'($urandom_range(0, 511)), 3'($urandom), ($urandom_range(0, 99) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
